// File: rtl/ervp_led_pattern_decoder.sv
// Receive side of the status-LED blink protocol: samples one LED line on the
// 62.5 ms tick and classifies it as DARK, RUNNING (symmetric blink) or FINISHED.
module ervp_led_pattern_decoder #(
    parameter int HALF_PERIOD  = 8,
    parameter int TOLERANCE    = 1,
    parameter int STEADY_TICKS = 24,
    parameter int DARK_TICKS   = 24,
    parameter int BW_RUN       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_62d5ms,
    input  logic              led_in,
    output logic [1:0]        status,
    output logic              status_valid,
    output logic              finished_pulse,
    output logic              period_error,
    output logic [BW_RUN-1:0] run_len
);

    typedef enum logic [1:0] {
        ST_UNKNOWN  = 2'd0,
        ST_DARK     = 2'd1,
        ST_RUNNING  = 2'd2,
        ST_FINISHED = 2'd3
    } state_t;

    localparam logic [BW_RUN:0]   HP_LO    = (BW_RUN+1)'(HALF_PERIOD - TOLERANCE);
    localparam logic [BW_RUN:0]   HP_HI    = (BW_RUN+1)'(HALF_PERIOD + TOLERANCE);
    localparam logic [BW_RUN:0]   STEADY_W = (BW_RUN+1)'(STEADY_TICKS);
    localparam logic [BW_RUN:0]   DARK_W   = (BW_RUN+1)'(DARK_TICKS);
    localparam logic [BW_RUN-1:0] RUN_MAX  = '1;

    logic [1:0]        sync_q;
    logic              prev_lvl_q, prev_lvl_d;
    logic [BW_RUN-1:0] run_len_q, run_len_d;
    logic              run_from_edge_q, run_from_edge_d;
    logic [1:0]        ok_cnt_q, ok_cnt_d;
    state_t            state_q, state_d;
    logic              status_valid_q, status_valid_d;
    logic              fin_pulse_q, fin_pulse_d;
    logic              perr_q, perr_d;

    logic              lvl;
    logic              lvl_edge;
    logic [BW_RUN:0]   run_ext;
    logic [BW_RUN:0]   run_inc;
    logic              in_tol;
    logic              valid_half;
    logic              invalid_half;
    logic [1:0]        ok_inc;

    assign lvl          = sync_q[1];
    assign lvl_edge     = (lvl != prev_lvl_q);
    assign run_ext      = {1'b0, run_len_q};
    assign run_inc      = run_ext + 1'b1;
    // A saturated run (L = max) is always outside tolerance, so it can never validate.
    assign in_tol       = (run_ext >= HP_LO) && (run_ext <= HP_HI);
    assign valid_half   = lvl_edge && run_from_edge_q && in_tol;
    assign invalid_half = lvl_edge && run_from_edge_q && !in_tol;
    assign ok_inc       = (ok_cnt_q == 2'd3) ? 2'd3 : ok_cnt_q + 2'd1;

    always_comb begin
        state_d         = state_q;
        prev_lvl_d      = prev_lvl_q;
        run_len_d       = run_len_q;
        run_from_edge_d = run_from_edge_q;
        ok_cnt_d        = ok_cnt_q;
        fin_pulse_d     = 1'b0;
        perr_d          = 1'b0;

        if (tick_62d5ms) begin
            if (lvl_edge) begin
                run_len_d       = {{(BW_RUN-1){1'b0}}, 1'b1};
                prev_lvl_d      = lvl;
                run_from_edge_d = 1'b1;
                if (valid_half) begin
                    ok_cnt_d = ok_inc;
                end else if (invalid_half) begin
                    ok_cnt_d = 2'd0;
                end
            end else if (run_len_q != RUN_MAX) begin
                run_len_d = run_len_q + 1'b1;
            end

            // Classification, highest priority first.
            if (invalid_half) begin
                perr_d = 1'b1;
                if (state_q == ST_RUNNING || state_q == ST_FINISHED) begin
                    state_d = ST_UNKNOWN;
                end
            end else if (lvl_edge && state_q == ST_FINISHED) begin
                perr_d  = 1'b1;
                state_d = ST_UNKNOWN;
            end else if (valid_half && ok_inc >= 2'd2) begin
                state_d = ST_RUNNING;
            end else if (!lvl_edge && lvl && run_inc >= STEADY_W) begin
                if (state_q != ST_FINISHED) begin
                    state_d     = ST_FINISHED;
                    fin_pulse_d = 1'b1;
                    ok_cnt_d    = 2'd0;
                end
            end else if (!lvl_edge && !lvl && run_inc >= DARK_W) begin
                if (state_q != ST_DARK) begin
                    state_d  = ST_DARK;
                    ok_cnt_d = 2'd0;
                    perr_d   = (state_q == ST_RUNNING);
                end
            end
        end

        status_valid_d = (state_d != ST_UNKNOWN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q          <= 2'b00;
            prev_lvl_q      <= 1'b0;
            run_len_q       <= '0;
            run_from_edge_q <= 1'b0;
            ok_cnt_q        <= 2'd0;
            state_q         <= ST_UNKNOWN;
            status_valid_q  <= 1'b0;
            fin_pulse_q     <= 1'b0;
            perr_q          <= 1'b0;
        end else begin
            sync_q          <= {sync_q[0], led_in};
            prev_lvl_q      <= prev_lvl_d;
            run_len_q       <= run_len_d;
            run_from_edge_q <= run_from_edge_d;
            ok_cnt_q        <= ok_cnt_d;
            state_q         <= state_d;
            status_valid_q  <= status_valid_d;
            fin_pulse_q     <= fin_pulse_d;
            perr_q          <= perr_d;
        end
    end

    assign status         = state_q;
    assign status_valid   = status_valid_q;
    assign finished_pulse = fin_pulse_q;
    assign period_error   = perr_q;
    assign run_len        = run_len_q;

endmodule
